// File: rtl/slow_clk_pkg.sv
// Shared definitions for the divided game clock: monitor FSM states and
// default timing constants also used by the divider's count.
package slow_clk_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } slow_clk_state_t;

    localparam int DEF_EXP_HALF   = 12500;
    localparam int DEF_TOL        = 64;
    localparam int DEF_LOCK_COUNT = 4;

    // Silence on the slow clock for a full nominal period means it is gone.
    function automatic int lost_limit(input int exp_half);
        return 2 * exp_half;
    endfunction

endpackage

// File: rtl/slow_clock_monitor_edge_sync.sv
// Synchronises the asynchronous slow clock into clk_in and turns each of its
// edges into a registered one-cycle rise or fall pulse.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    assign level = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= level;
            rise   <= level & ~prev_q;
            fall   <= ~level & prev_q;
        end
    end

endmodule

// File: rtl/slow_clock_monitor.sv
// Slow clock consumer: edge ticks, half/full period measurement, lock and loss
// detection. Define SLOW_CLK_STATS_EN to add the glitch_cnt statistics output.
//
// state   | meaning
// IDLE    | out of reset, no edge seen yet
// ACQUIRE | measuring halves, counting consecutive good ones
// LOCKED  | LOCK_COUNT good halves in a row seen
// LOST    | no edge for 2*EXP_HALF cycles
module slow_clock_monitor
    import slow_clk_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EXP_HALF    = DEF_EXP_HALF,
    parameter int TOL         = DEF_TOL,
    parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int CNT_W       = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             slow_clk,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic             locked,
    output logic             lost,
    output logic [CNT_W-1:0] period,
    output logic             period_valid
`ifdef SLOW_CLK_STATS_EN
    ,
    output logic [7:0]       glitch_cnt
`endif
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]  HCNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  TIMEOUT   = CNT_W'(lost_limit(EXP_HALF));
    localparam logic [CNT_W-1:0]  EXP_V     = CNT_W'(EXP_HALF);
    localparam logic [CNT_W-1:0]  TOL_V     = CNT_W'(TOL);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [GOOD_W-1:0] GOOD_FULL = GOOD_W'(LOCK_COUNT);

    slow_clk_state_t   state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [CNT_W-1:0]  hcnt_q;
    logic [CNT_W-1:0]  last_half_q;
    logic              have_half_q;
    logic [CNT_W-1:0]  period_q;
    logic              period_valid_q;

    logic              tick;
    logic              timeout;
    logic              measure;
    logic [CNT_W-1:0]  half_dev;
    logic              half_good;
    logic [CNT_W:0]    half_sum;
    logic [CNT_W-1:0]  period_sat;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .async_in(slow_clk),
        .rise    (rise_tick),
        .fall    (fall_tick)
    );

    assign tick    = rise_tick | fall_tick;
    assign timeout = (hcnt_q >= TIMEOUT);

    // Unsigned distance from the nominal half, computed without wrap.
    assign half_dev  = (hcnt_q >= EXP_V) ? (hcnt_q - EXP_V) : (EXP_V - hcnt_q);
    assign half_good = (half_dev <= TOL_V);

    assign half_sum   = {1'b0, last_half_q} + {1'b0, hcnt_q};
    assign period_sat = half_sum[CNT_W] ? HCNT_MAX : half_sum[CNT_W-1:0];

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        measure = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end else if (timeout) begin
                    state_d = LOST;
                end
            end
            ACQUIRE: begin
                if (tick) begin
                    measure = 1'b1;
                    if (!half_good) begin
                        good_d = '0;
                    end else if (good_q == GOOD_LAST) begin
                        state_d = LOCKED;
                        good_d  = GOOD_FULL;
                    end else begin
                        good_d = good_q + GOOD_W'(1);
                    end
                end else if (timeout) begin
                    state_d = LOST;
                    good_d  = '0;
                end
            end
            LOCKED: begin
                if (tick) begin
                    measure = 1'b1;
                    if (!half_good) begin
                        state_d = ACQUIRE;
                        good_d  = '0;
                    end
                end else if (timeout) begin
                    state_d = LOST;
                    good_d  = '0;
                end
            end
            LOST: begin
                if (tick) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                good_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            good_q         <= '0;
            hcnt_q         <= '0;
            last_half_q    <= '0;
            have_half_q    <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            good_q         <= good_d;
            period_valid_q <= 1'b0;

            if (tick) begin
                hcnt_q <= CNT_W'(1);
            end else if (hcnt_q != HCNT_MAX) begin
                hcnt_q <= hcnt_q + CNT_W'(1);
            end

            // A half only counts towards period if the previous one was also
            // fully measured; discarded halves and timeouts break the chain.
            if (measure) begin
                last_half_q <= hcnt_q;
                have_half_q <= 1'b1;
                if (rise_tick && have_half_q) begin
                    period_q       <= period_sat;
                    period_valid_q <= 1'b1;
                end
            end else if (state_d == IDLE || state_d == LOST) begin
                have_half_q <= 1'b0;
            end
        end
    end

    assign locked       = (state_q == LOCKED);
    assign lost         = (state_q == LOST);
    assign period       = period_q;
    assign period_valid = period_valid_q;

`ifdef SLOW_CLK_STATS_EN
    logic [7:0] glitch_q;
    logic       leave_lock;

    // LOCKED is only ever left through a bad half or a timeout.
    assign leave_lock = (state_q == LOCKED) && (state_d != LOCKED);

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            glitch_q <= '0;
        end else if (leave_lock && glitch_q != 8'hFF) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule
